escape_status_tracker: RTL

- Downstream consumer of the escape-room puzzle FSM.
- Watches the FSM's `state`/`prevState` outputs and keeps the game-level bookkeeping:
  - rooms cleared
  - lives remaining
  - per-room countdown timer
  - final win/lose verdict and which ending was reached
- Outputs drive the scoreboard/LED display logic.

---
 rtl/escape_status_tracker_if.sv | 30 +++
 rtl/escape_status_tracker.sv | 138 +++++++++++++
 2 files changed

// File: rtl/escape_status_tracker_if.sv
// Bundle between the puzzle FSM side and the game-status tracker.
// master: drives the FSM state/prevState and observes the bookkeeping.
// slave: the tracker; consumes state and presents the scoreboard outputs.
interface escape_status_tracker_if #(
  parameter int unsigned TW = 16
);
  logic [3:0]    state;
  logic [3:0]    prevState;
  logic [2:0]    rooms_cleared;
  logic [1:0]    lives_left;
  logic [TW-1:0] time_left;
  logic [3:0]    last_room;
  logic          fail_pulse;
  logic          timeout_pulse;
  logic          win;
  logic          lose;
  logic [1:0]    ending;

  modport master (
    output state, prevState,
    input  rooms_cleared, lives_left, time_left, last_room,
    input  fail_pulse, timeout_pulse, win, lose, ending
  );

  modport slave (
    input  state, prevState,
    output rooms_cleared, lives_left, time_left, last_room,
    output fail_pulse, timeout_pulse, win, lose, ending
  );
endinterface

// File: rtl/escape_status_tracker.sv
// Game-level bookkeeping for the escape-room puzzle FSM: rooms cleared,
// lives, per-room countdown, and the final win/lose verdict. All outputs
// are registered and respond one cycle after the input change.
module escape_status_tracker #(
  parameter int unsigned LIVES      = 3,
  parameter int unsigned ROOM_TICKS = 1000,
  parameter int unsigned TW         = 16
) (
  input logic                    clk,
  input logic                    reset,
  escape_status_tracker_if.slave bus
);

  // Puzzle FSM state codes of interest; 9..15 are invalid.
  typedef enum logic [3:0] {
    ROOM_0 = 4'd0,
    ROOM_5 = 4'd5,
    END_A  = 4'd6,
    END_B  = 4'd7,
    FAILED = 4'd8
  } code_t;

  // Game phase; win/lose are decoded from it so they stay sticky.
  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WON  = 2'd1,
    LOST = 2'd2
  } phase_t;

  localparam logic [TW-1:0] TICKS_RELOAD = TW'(ROOM_TICKS);
  localparam logic [1:0]    LIVES_INIT   = 2'(LIVES);

  phase_t        phase_q, phase_n;
  logic [3:0]    state_q;
  logic [3:0]    last_q;
  logic [2:0]    rooms_q, rooms_n;
  logic [1:0]    lives_q, lives_n;
  logic [TW-1:0] ticks_q, ticks_n;
  logic [1:0]    ending_q, ending_n;
  logic          fail_q, fail_n;
  logic          tmo_q, tmo_n;
  logic          change;
  logic          in_room;
  logic          advance;

  assign change  = (bus.state != state_q);
  assign in_room = (bus.state <= ROOM_5);
  assign advance = (bus.state != ROOM_0) && in_room &&
                   (bus.state == 4'(state_q + 4'd1));

  // Next-state and next-output computation in event priority order.
  always_comb begin
    phase_n  = phase_q;
    rooms_n  = rooms_q;
    lives_n  = lives_q;
    ticks_n  = ticks_q;
    ending_n = ending_q;
    fail_n   = 1'b0;
    tmo_n    = 1'b0;

    // Once game over, everything but state_q/last_room holds; pulses drop.
    if (phase_q == PLAY) begin
      if (change) begin
        if (bus.state == END_A || bus.state == END_B) begin
          phase_n  = WON;
          ending_n = (bus.state == END_A) ? 2'd1 : 2'd2;
        end else if (bus.state == FAILED) begin
          fail_n = 1'b1;
          if (lives_q <= 2'd1) begin
            lives_n = '0;
            phase_n = LOST;
          end else begin
            lives_n = lives_q - 2'd1;
          end
        end else if (bus.state == ROOM_0) begin
          rooms_n = '0;
          ticks_n = TICKS_RELOAD;
        end else if (advance) begin
          if (rooms_q < 3'd5) begin
            rooms_n = rooms_q + 3'd1;
          end
          ticks_n = TICKS_RELOAD;
        end else begin
          ticks_n = TICKS_RELOAD;
        end
      end else if (in_room) begin
        if (ticks_q != '0) begin
          ticks_n = ticks_q - TW'(1);
        end else begin
          tmo_n   = 1'b1;
          ticks_n = TICKS_RELOAD;
          if (lives_q <= 2'd1) begin
            lives_n = '0;
            phase_n = LOST;
          end else begin
            lives_n = lives_q - 2'd1;
          end
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q  <= PLAY;
      state_q  <= '0;
      last_q   <= '0;
      rooms_q  <= '0;
      lives_q  <= LIVES_INIT;
      ticks_q  <= TICKS_RELOAD;
      ending_q <= '0;
      fail_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      phase_q  <= phase_n;
      state_q  <= bus.state;
      last_q   <= bus.prevState;
      rooms_q  <= rooms_n;
      lives_q  <= lives_n;
      ticks_q  <= ticks_n;
      ending_q <= ending_n;
      fail_q   <= fail_n;
      tmo_q    <= tmo_n;
    end
  end

  assign bus.rooms_cleared = rooms_q;
  assign bus.lives_left    = lives_q;
  assign bus.time_left     = ticks_q;
  assign bus.last_room     = last_q;
  assign bus.fail_pulse    = fail_q;
  assign bus.timeout_pulse = tmo_q;
  assign bus.win           = (phase_q == WON);
  assign bus.lose          = (phase_q == LOST);
  assign bus.ending        = ending_q;

endmodule
